serial_tx: RTL

Parallel-in, serial-out frame transmitter. It accepts one data word over a ready/load handshake and shifts it out on a single line as start bit, data bits LSB first, optional parity and stop bit. Each bit is held for a programmable number of clocks. It drives the serial line that a downstream chain of D flip-flops samples, and sits between the datapath and any bit-serial link or display shift chain.

---
 rtl/serial_tx_if.sv | 29 ++
 rtl/serial_tx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_if.sv
// serial_tx_if: load/ready handshake, parallel word and serial line of serial_tx.
interface serial_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] Di;
    logic              load;
    logic              ready;
    logic              busy;
    logic              done;
    logic              So;

    modport master (
        output Di,
        output load,
        input  ready,
        input  busy,
        input  done,
        input  So
    );

    modport slave (
        input  Di,
        input  load,
        output ready,
        output busy,
        output done,
        output So
    );
endinterface

// File: rtl/serial_tx.sv
// serial_tx: parallel-in, serial-out frame transmitter.
// Frame = start(0), DATA_W data bits LSB first, [even parity], stop(1),
// each bit held CLK_DIV clocks. All outputs are registered.
// Optional parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    serial_tx_if.slave  bus
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef SERIAL_TX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                so_q, so_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef SERIAL_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic bit_end_c;
    assign bit_end_c = (cnt_q == '0);

    // Next-state, bit timer, shift register and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        so_d    = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    state_d = S_START;
                    cnt_d   = CNT_RELOAD;
                    idx_d   = '0;
                    shreg_d = bus.Di;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^bus.Di;
`endif
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    cnt_d   = CNT_RELOAD;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d = S_STOP;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end_c) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge
        case (state_d)
            S_START:  so_d = 1'b0;
            S_DATA:   so_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: so_d = par_d;
`endif
            default:  so_d = 1'b1;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = ~ready_d;
        done_d  = (state_d == S_STOP) && (cnt_d == '0);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            so_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            so_q    <= so_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.So    = so_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
